// File: rtl/m_mc_ctrl.sv
// ---------------------------------------------------------------------------
// m_mc_ctrl -- multi-cycle processor control FSM
//
// Sequences one instruction at a time through IF -> ID -> EX -> [MEM] -> [WB],
// waits on instruction/data memory ready with a bounded wait counter, counts
// retired instructions and latches a sticky error.
//
// Ports
//   w_clk        in   sole clock, rising edge
//   w_rst        in   asynchronous active-high reset
//   w_imem_rdy   in   instruction word valid this cycle
//   w_dmem_rdy   in   data memory access complete this cycle
//   w_ld, w_s    in   decoded load / store from the current IR
//   w_halt       in   level-sensitive halt request
//   w_im_req     out  instruction fetch request
//   w_ir_we      out  instruction register load enable
//   w_dm_req     out  data memory request
//   w_dm_we      out  data memory write qualifier (only with w_dm_req)
//   w_rf_we      out  register file write enable
//   w_pc_we      out  PC update enable
//   w_state      out  current state encoding
//   w_instret    out  retired-instruction counter (wraps)
//   w_err        out  sticky error flag
// ---------------------------------------------------------------------------
module m_mc_ctrl #(
    parameter int WAIT_MAX = 8
) (
    input  logic        w_clk,
    input  logic        w_rst,
    input  logic        w_imem_rdy,
    input  logic        w_dmem_rdy,
    input  logic        w_ld,
    input  logic        w_s,
    input  logic        w_halt,
    output logic        w_im_req,
    output logic        w_ir_we,
    output logic        w_dm_req,
    output logic        w_dm_we,
    output logic        w_rf_we,
    output logic        w_pc_we,
    output logic [2:0]  w_state,
    output logic [31:0] w_instret,
    output logic        w_err
);

    typedef enum logic [2:0] {
        ST_IF   = 3'd0,
        ST_ID   = 3'd1,
        ST_EX   = 3'd2,
        ST_MEM  = 3'd3,
        ST_WB   = 3'd4,
        ST_HALT = 3'd5,
        ST_ERR  = 3'd6,
        ST_BAD  = 3'd7
    } state_t;

    localparam logic [7:0] WAIT_MAX_C = WAIT_MAX[7:0];

    state_t      state_r;
    state_t      state_nxt_s;
    logic [7:0]  wait_cnt_r;
    logic [7:0]  wait_cnt_nxt_s;
    logic [31:0] instret_r;
    logic        err_r;
    logic        retire_s;
    logic        wait_at_max_s;
    logic        im_req_s;
    logic        ir_we_s;
    logic        dm_req_s;
    logic        dm_we_s;
    logic        rf_we_s;
    logic        pc_we_s;

    assign wait_at_max_s = (wait_cnt_r == WAIT_MAX_C);

    // Next-state and Moore/Mealy control decode
    always_comb begin
        state_nxt_s = state_r;
        retire_s    = 1'b0;
        im_req_s    = 1'b0;
        ir_we_s     = 1'b0;
        dm_req_s    = 1'b0;
        dm_we_s     = 1'b0;
        rf_we_s     = 1'b0;
        pc_we_s     = 1'b0;
        case (state_r)
            ST_IF: begin
                im_req_s = 1'b1;
                if (w_imem_rdy) begin
                    ir_we_s     = 1'b1;
                    state_nxt_s = ST_ID;
                end else if (wait_at_max_s) begin
                    state_nxt_s = ST_ERR;
                end else begin
                    state_nxt_s = ST_IF;
                end
            end
            ST_ID: begin
                state_nxt_s = ST_EX;
            end
            ST_EX: begin
                // load and store together is an illegal decode
                if (w_ld & w_s) begin
                    state_nxt_s = ST_ERR;
                end else if (w_ld ^ w_s) begin
                    state_nxt_s = ST_MEM;
                end else begin
                    state_nxt_s = ST_WB;
                end
            end
            ST_MEM: begin
                dm_req_s = 1'b1;
                dm_we_s  = w_s;
                if (w_dmem_rdy) begin
                    if (w_s) begin
                        // store retires straight out of MEM
                        pc_we_s     = 1'b1;
                        retire_s    = 1'b1;
                        state_nxt_s = w_halt ? ST_HALT : ST_IF;
                    end else begin
                        state_nxt_s = ST_WB;
                    end
                end else if (wait_at_max_s) begin
                    state_nxt_s = ST_ERR;
                end else begin
                    state_nxt_s = ST_MEM;
                end
            end
            ST_WB: begin
                rf_we_s     = 1'b1;
                pc_we_s     = 1'b1;
                retire_s    = 1'b1;
                state_nxt_s = w_halt ? ST_HALT : ST_IF;
            end
            ST_HALT: begin
                if (w_halt) begin
                    state_nxt_s = ST_HALT;
                end else begin
                    state_nxt_s = ST_IF;
                end
            end
            ST_ERR: begin
                state_nxt_s = ST_ERR;
            end
            default: begin
                state_nxt_s = ST_ERR;
            end
        endcase
    end

    // Wait counter: counts stall cycles while a wait state holds, clears otherwise
    always_comb begin
        if (((state_r == ST_IF) || (state_r == ST_MEM)) && (state_nxt_s == state_r)) begin
            wait_cnt_nxt_s = wait_cnt_r + 8'd1;
        end else begin
            wait_cnt_nxt_s = 8'd0;
        end
    end

    // State, wait counter, retire counter and sticky error registers
    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            state_r    <= ST_IF;
            wait_cnt_r <= 8'd0;
            instret_r  <= 32'd0;
            err_r      <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            wait_cnt_r <= wait_cnt_nxt_s;
            if (retire_s) begin
                instret_r <= instret_r + 32'd1;
            end
            err_r <= err_r | (state_nxt_s == ST_ERR);
        end
    end

    // Controls are combinational; reset masks them so nothing writes during reset
    assign w_im_req  = im_req_s & ~w_rst;
    assign w_ir_we   = ir_we_s  & ~w_rst;
    assign w_dm_req  = dm_req_s & ~w_rst;
    assign w_dm_we   = dm_we_s  & ~w_rst;
    assign w_rf_we   = rf_we_s  & ~w_rst;
    assign w_pc_we   = pc_we_s  & ~w_rst;
    assign w_state   = state_r;
    assign w_instret = instret_r;
    assign w_err     = err_r;

endmodule

// File: tb/tb_m_mc_ctrl.sv
// ---------------------------------------------------------------------------
// tb_m_mc_ctrl -- self-checking bench for m_mc_ctrl
//
// Each instruction is planned at transaction level (kind, memory wait counts,
// halt request) and expanded into the expected per-cycle state and control
// pattern, which is compared against the DUT one cycle at a time.
// ---------------------------------------------------------------------------
module tb_m_mc_ctrl;

    localparam int WM = 8;

    localparam logic [2:0] E_IF = 3'd0, E_ID = 3'd1, E_EX = 3'd2, E_MEM = 3'd3,
                           E_WB = 3'd4, E_HALT = 3'd5, E_ERR = 3'd6;

    logic        w_clk = 1'b0;
    logic        w_rst = 1'b1;
    logic        w_imem_rdy = 1'b0;
    logic        w_dmem_rdy = 1'b0;
    logic        w_ld = 1'b0;
    logic        w_s = 1'b0;
    logic        w_halt = 1'b0;
    logic        w_im_req, w_ir_we, w_dm_req, w_dm_we, w_rf_we, w_pc_we;
    logic [2:0]  w_state;
    logic [31:0] w_instret;
    logic        w_err;
    logic [5:0]  ctl_s;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_instret = 32'd0;

    assign ctl_s = {w_im_req, w_ir_we, w_dm_req, w_dm_we, w_rf_we, w_pc_we};

    m_mc_ctrl #(.WAIT_MAX(WM)) dut (
        .w_clk      (w_clk),
        .w_rst      (w_rst),
        .w_imem_rdy (w_imem_rdy),
        .w_dmem_rdy (w_dmem_rdy),
        .w_ld       (w_ld),
        .w_s        (w_s),
        .w_halt     (w_halt),
        .w_im_req   (w_im_req),
        .w_ir_we    (w_ir_we),
        .w_dm_req   (w_dm_req),
        .w_dm_we    (w_dm_we),
        .w_rf_we    (w_rf_we),
        .w_pc_we    (w_pc_we),
        .w_state    (w_state),
        .w_instret  (w_instret),
        .w_err      (w_err)
    );

    always #5 w_clk = ~w_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Inputs are already driven; check this cycle, then advance to the next negedge.
    task automatic step(input logic [2:0] es, input logic [5:0] ectl);
        #1;
        check("state", {29'd0, w_state}, {29'd0, es});
        check("ctl", {26'd0, ctl_s}, {26'd0, ectl});
        @(posedge w_clk);
        @(negedge w_clk);
    endtask

    task automatic do_reset();
        w_rst      = 1'b1;
        w_imem_rdy = 1'b1;
        w_dmem_rdy = 1'b1;
        w_ld       = 1'($urandom);
        w_s        = 1'($urandom);
        w_halt     = 1'($urandom);
        #1;
        check("rst_state", {29'd0, w_state}, 32'd0);
        check("rst_ctl", {26'd0, ctl_s}, 32'd0);
        @(posedge w_clk);
        @(negedge w_clk);
        check("rst_instret", w_instret, 32'd0);
        check("rst_err", {31'd0, w_err}, 32'd0);
        check("rst_ctl2", {26'd0, ctl_s}, 32'd0);
        w_rst       = 1'b0;
        exp_instret = 32'd0;
    endtask

    task automatic err_phase();
        for (int k = 0; k < 3; k++) begin
            w_imem_rdy = 1'($urandom);
            w_dmem_rdy = 1'($urandom);
            w_halt     = 1'($urandom);
            step(E_ERR, 6'b000000);
            check("err_flag", {31'd0, w_err}, 32'd1);
        end
        do_reset();
    endtask

    task automatic retire_done(input bit hlt, input int hlen);
        exp_instret = exp_instret + 32'd1;
        check("instret", w_instret, exp_instret);
        check("no_err", {31'd0, w_err}, 32'd0);
        if (hlt) begin
            for (int k = 0; k < hlen; k++) begin
                w_halt = 1'b1;
                step(E_HALT, 6'b000000);
            end
            w_halt = 1'b0;
            step(E_HALT, 6'b000000);
        end
    endtask

    // One instruction: iw/dw are low-ready cycles before ready; above WM means timeout.
    task automatic run_instr(input bit ld, input bit s, input int iw, input int dw,
                             input bit hlt, input int hlen);
        int nlow;
        nlow = (iw > WM) ? WM + 1 : iw;
        for (int k = 0; k < nlow; k++) begin
            w_imem_rdy = 1'b0;
            w_dmem_rdy = 1'($urandom);
            w_ld = 1'($urandom); w_s = 1'($urandom); w_halt = 1'($urandom);
            step(E_IF, 6'b100000);
        end
        if (iw > WM) begin
            err_phase();
            return;
        end
        w_imem_rdy = 1'b1;
        w_halt = 1'($urandom);
        step(E_IF, 6'b110000);
        w_ld = ld; w_s = s;
        w_imem_rdy = 1'($urandom);
        w_halt = 1'($urandom);
        step(E_ID, 6'b000000);
        w_halt = 1'($urandom);
        step(E_EX, 6'b000000);
        if (ld && s) begin
            err_phase();
            return;
        end
        if (ld || s) begin
            nlow = (dw > WM) ? WM + 1 : dw;
            for (int k = 0; k < nlow; k++) begin
                w_dmem_rdy = 1'b0;
                w_halt = 1'($urandom);
                step(E_MEM, {2'b00, 1'b1, s, 2'b00});
            end
            if (dw > WM) begin
                err_phase();
                return;
            end
            w_dmem_rdy = 1'b1;
            if (s) begin
                w_halt = hlt;
                step(E_MEM, 6'b001101);
                retire_done(hlt, hlen);
                return;
            end
            w_halt = 1'($urandom);
            step(E_MEM, 6'b001000);
        end
        w_halt = hlt;
        w_dmem_rdy = 1'($urandom);
        step(E_WB, 6'b000011);
        retire_done(hlt, hlen);
    endtask

    function automatic int pick_wait();
        int r;
        r = int'($urandom_range(0, 9));
        if (r < 7) return int'($urandom_range(0, 3));
        if (r == 7) return WM;
        if (r == 8) return WM - 1;
        return WM + 1;
    endfunction

    initial begin
        @(negedge w_clk);
        do_reset();

        // directed: ALU, slow load, store, fetch ready on last legal cycle
        run_instr(1'b0, 1'b0, 0, 0, 1'b0, 0);
        run_instr(1'b1, 1'b0, 0, 3, 1'b0, 0);
        run_instr(1'b0, 1'b1, 0, 0, 1'b0, 0);
        run_instr(1'b0, 1'b0, WM, 0, 1'b0, 0);
        run_instr(1'b1, 1'b0, 0, WM, 1'b0, 0);
        // halt in WB held 3 cycles, then halt in store completion
        run_instr(1'b0, 1'b0, 1, 0, 1'b1, 3);
        run_instr(1'b0, 1'b1, 0, 1, 1'b1, 1);
        // fetch timeout, data timeout, illegal decode
        run_instr(1'b0, 1'b0, WM + 1, 0, 1'b0, 0);
        run_instr(1'b0, 1'b1, 0, WM + 1, 1'b0, 0);
        run_instr(1'b1, 1'b1, 0, 0, 1'b0, 0);

        // counter wrap
        run_instr(1'b0, 1'b0, 0, 0, 1'b0, 0);
        force dut.instret_r = 32'hFFFF_FFFF;
        #1;
        release dut.instret_r;
        exp_instret = 32'hFFFF_FFFF;
        run_instr(1'b0, 1'b0, 0, 0, 1'b0, 0);
        check("wrap", w_instret, 32'd0);
        run_instr(1'b1, 1'b0, 1, 0, 1'b0, 0);

        // reset pulsed while a store waits in MEM
        w_imem_rdy = 1'b1;
        step(E_IF, 6'b110000);
        w_ld = 1'b0; w_s = 1'b1;
        step(E_ID, 6'b000000);
        step(E_EX, 6'b000000);
        w_dmem_rdy = 1'b0;
        step(E_MEM, 6'b001100);
        w_rst = 1'b1;
        w_dmem_rdy = 1'b1;
        #1;
        check("mem_rst_dmwe", {31'd0, w_dm_we}, 32'd0);
        check("mem_rst_state", {29'd0, w_state}, 32'd0);
        @(negedge w_clk);
        check("mem_rst_instret", w_instret, 32'd0);
        do_reset();

        // randomized traffic
        for (int n = 0; n < 80; n++) begin
            int kind;
            bit ld, s, hlt;
            kind = int'($urandom_range(0, 19));
            ld  = (kind < 7) || (kind == 19);
            s   = ((kind >= 7) && (kind < 13)) || (kind == 19);
            hlt = ($urandom_range(0, 5) == 0);
            run_instr(ld, s, pick_wait(), pick_wait(), hlt, int'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/m_mc_ctrl.md
M_MC_CTRL -- requirements
Module: m_mc_ctrl

Interface
REQ-001 Parameter WAIT_MAX, default 8: maximum number of extra cycles a memory ready may be awaited before error; legal range 1..255.
REQ-002 w_clk  in  1  sole clock; all state updates on posedge w_clk.
REQ-003 w_rst  in  1  reset, asynchronous, active-high.
REQ-004 w_imem_rdy  in  1  instruction memory word valid this cycle.
REQ-005 w_dmem_rdy  in  1  data memory access complete this cycle.
REQ-006 w_ld  in  1  decoded load, taken from the current IR; valid from ID onward.
REQ-007 w_s  in  1  decoded store, taken from the current IR; valid from ID onward.
REQ-008 w_halt  in  1  halt request, level-sensitive.
REQ-009 w_im_req  out  1  instruction fetch request.
REQ-010 w_ir_we  out  1  instruction register load enable.
REQ-011 w_dm_req  out  1  data memory request.
REQ-012 w_dm_we  out  1  data memory write qualifier; valid only with w_dm_req.
REQ-013 w_rf_we  out  1  register file write enable.
REQ-014 w_pc_we  out  1  PC update enable; the next-PC source is external.
REQ-015 w_state  out  3  current state encoding.
REQ-016 w_instret  out  32  retired-instruction counter.
REQ-017 w_err  out  1  sticky error flag.

Function
REQ-018 The FSM SHALL use these state encodings: IF=0, ID=1, EX=2, MEM=3, WB=4, HALT=5, ERR=6; value 7 is unreachable and SHALL go to ERR.
REQ-019 All control outputs (w_im_req, w_ir_we, w_dm_req, w_dm_we, w_rf_we, w_pc_we) SHALL be Moore/Mealy combinational from the state and inputs, with no added latency.
REQ-020 IF SHALL drive w_im_req=1; on w_imem_rdy=1 it SHALL drive w_ir_we=1 in the same cycle and go to ID; otherwise it SHALL hold in IF.
REQ-021 ID SHALL last exactly 1 cycle and then go to EX.
REQ-022 EX SHALL go to MEM if w_ld^w_s, to ERR if w_ld&w_s, and to WB otherwise.
REQ-023 MEM SHALL drive w_dm_req=1 and w_dm_we=w_s; on w_dmem_rdy=1 a load SHALL go to WB, and a store SHALL drive w_pc_we=1, retire, and go to IF (or HALT per REQ-026).
REQ-024 WB SHALL drive w_rf_we=1 and w_pc_we=1, retire, and go to IF (or HALT per REQ-026).
REQ-025 w_rf_we SHALL never assert for a store; w_dm_we SHALL never assert outside MEM.
REQ-026 w_halt SHALL be sampled only in the retire cycle: if it is 1, the next state SHALL be HALT instead of IF.
REQ-027 HALT SHALL assert no control outputs, and SHALL go to IF on the first cycle that w_halt=0.
REQ-028 A wait counter (8 bits) SHALL clear on every entry to IF or MEM and increment each cycle that ready is low in that state.
REQ-029 If ready is low while the wait counter equals WAIT_MAX, the FSM SHALL go to ERR.
REQ-030 Ready arriving in the same cycle that the counter equals WAIT_MAX SHALL be accepted normally, with no error.
REQ-031 ERR SHALL set w_err=1, assert no control outputs, and be left only by reset.
REQ-032 w_instret SHALL increment by 1 on each retire cycle (WB exit or store MEM completion) and wrap from 0xFFFFFFFF to 0.
REQ-033 Latency with zero-wait memories SHALL be: ALU/other 4 cycles (IF, ID, EX, WB); load 5 cycles; store 4 cycles (IF, ID, EX, MEM).

Reset
REQ-034 While w_rst=1 the block SHALL force state=IF, wait counter=0, w_instret=0, and w_err=0, and all write enables (w_ir_we, w_rf_we, w_dm_we, w_pc_we) SHALL be 0 regardless of inputs.
REQ-035 Reset asserted mid-instruction (any state, including ERR or HALT) SHALL abort with no retire and no w_instret increment, and restart at IF on the first clock edge after deassertion.

Verification
REQ-036 ALU op with imem_rdy and dmem_rdy tied 1, w_ld=w_s=0 -> states 0,1,2,4,0; rf_we and pc_we high in cycle 4 only; instret=1.
REQ-037 Load, dmem_rdy low 3 cycles -> MEM held 4 cycles, dm_we=0, then WB with rf_we=1; total 8 cycles; instret+1.
REQ-038 Store with dmem_rdy=1 -> dm_req=dm_we=pc_we=1 in MEM, rf_we never 1, next state IF; instret+1.
REQ-039 imem_rdy held 0, WAIT_MAX=8 -> 9 IF cycles then state=6, err=1 persists until w_rst; rdy in the 9th cycle instead -> normal ID.
REQ-040 w_halt=1 during WB -> state=5 and held; w_halt drops -> IF next cycle; w_halt toggling mid-EX has no effect.
REQ-041 Preload instret near 0xFFFFFFFF (run 2^32 retires or force) -> wraps to 0; w_rst pulsed in MEM -> state=0, instret=0, no dm_we after the edge.
